// File: rtl/imem_line_responder_if.sv
// Line-fill handshake between the instruction cache (master) and memory (slave).
interface imem_line_responder_if #(
  parameter int unsigned ARCH_LEN = 32,
  parameter int unsigned ICLLEN   = 128
);
  logic                bus_ldp;
  logic [ARCH_LEN-1:0] bus_addr;
  logic                bus_ldr;
  logic [ICLLEN-1:0]   bus_data;

  modport master (
    output bus_ldp,
    output bus_addr,
    input  bus_ldr,
    input  bus_data
  );

  modport slave (
    input  bus_ldp,
    input  bus_addr,
    output bus_ldr,
    output bus_data
  );
endinterface

// File: rtl/imem_line_responder.sv
// Memory-side line-fill responder: accepts a line request, waits a fixed
// latency, then returns one full cache line with a single-cycle ldr pulse.
// Program storage is a word array preloaded through a simple write port.
module imem_line_responder #(
  parameter int unsigned ARCH_LEN  = 32,
  parameter int unsigned ICLLEN    = 128,
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                clk,
  input  logic                rst,
  imem_line_responder_if.slave bus,
  output logic                busy,
  input  logic                wr_en,
  input  logic [ARCH_LEN-1:0] wr_addr,
  input  logic [31:0]         wr_data
);

  localparam int unsigned WPL = ICLLEN / 32;
  localparam int unsigned IW  = $clog2(MEM_WORDS);
  localparam int unsigned LW  = $clog2(ICLLEN / 8) - 2;
  localparam int unsigned CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_base_idx;
  logic                r_ldr;
  logic                r_busy;
  logic [ICLLEN-1:0]   r_data;
  logic [31:0]         r_mem [MEM_WORDS];

  logic [IW-1:0]       w_req_idx;
  logic [IW-1:0]       w_req_base;
  logic [IW-1:0]       w_wr_idx;
  logic [ICLLEN-1:0]   w_line;
  logic                w_unused;

  // Word indices: upper address bits are dropped so addresses wrap.
  assign w_req_idx  = bus.bus_addr[IW+1:2];
  assign w_req_base = (w_req_idx >> LW) << LW;
  assign w_wr_idx   = wr_addr[IW+1:2];
  assign w_unused   = ^{bus.bus_addr[ARCH_LEN-1:IW+2], bus.bus_addr[1:0],
                        wr_addr[ARCH_LEN-1:IW+2], wr_addr[1:0]};

  // Preload write port; storage survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  // Assemble the line at the captured base, forwarding a same-edge write.
  always_comb begin
    w_line = '0;
    for (int k = 0; k < WPL; k++) begin
      if (wr_en && (w_wr_idx == (r_base_idx + IW'(k)))) begin
        w_line[32*k +: 32] = wr_data;
      end else begin
        w_line[32*k +: 32] = r_mem[r_base_idx + IW'(k)];
      end
    end
  end

  // IDLE/WAIT/RESP sequencer with registered ldr, data and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_base_idx <= '0;
      r_ldr      <= 1'b0;
      r_busy     <= 1'b0;
      r_data     <= '0;
    end else begin
      r_ldr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.bus_ldp) begin
            r_base_idx <= w_req_base;
            r_cnt      <= CW'(LATENCY - 1);
            r_state    <= S_WAIT;
            r_busy     <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_RESP;
            r_ldr   <= 1'b1;
            r_data  <= w_line;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_ldr  = r_ldr;
  assign bus.bus_data = r_data;
  assign busy         = r_busy;

endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder: LATENCY=4 instance for most steps,
// LATENCY=1 instance for the short-latency step. Expected lines are queued
// when a request is issued and popped when the response is compared.
module tb_imem_line_responder;

  localparam int unsigned ARCH_LEN = 32;
  localparam int unsigned ICLLEN   = 128;

  logic        clk;
  logic        rst;
  logic        busy_a, busy_b;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [31:0]       model [4096];
  logic [ICLLEN-1:0] sb [$];

  imem_line_responder_if #(.ARCH_LEN(ARCH_LEN), .ICLLEN(ICLLEN)) bus_a ();
  imem_line_responder_if #(.ARCH_LEN(ARCH_LEN), .ICLLEN(ICLLEN)) bus_b ();

  imem_line_responder #(.ARCH_LEN(ARCH_LEN), .ICLLEN(ICLLEN), .MEM_WORDS(4096), .LATENCY(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  imem_line_responder #(.ARCH_LEN(ARCH_LEN), .ICLLEN(ICLLEN), .MEM_WORDS(4096), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    model[a[13:2]] = d;
    tick();
    wr_en = 1'b0;
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [11:0]  base;
    logic [127:0] l;
    base = a[13:2] & ~12'h3;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = model[base + 12'(k)];
    return l;
  endfunction

  // Observe one instance for a bounded number of cycles at falling edges.
  task automatic mon(input bit use_b, input int cycles, output int n_ldr,
                     output int first_at, output int n_busy, output logic [127:0] first_data);
    n_ldr = 0; first_at = -1; n_busy = 0; first_data = '0;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      if (use_b ? busy_b : busy_a) n_busy++;
      if (use_b ? bus_b.bus_ldr : bus_a.bus_ldr) begin
        n_ldr++;
        if (n_ldr == 1) begin
          first_at   = c;
          first_data = use_b ? bus_b.bus_data : bus_a.bus_data;
        end
      end
    end
  endtask

  initial begin
    int n, at, nb, at1, at2;
    logic [127:0] d, d1, d2;

    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    bus_a.bus_ldp = 1'b0; bus_a.bus_addr = '0;
    bus_b.bus_ldp = 1'b0; bus_b.bus_addr = '0;
    for (int i = 0; i < 4096; i++) model[i] = '0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 128'(busy_a), 128'(0));
    chk("rst_ldr",  128'(bus_a.bus_ldr), 128'(0));
    chk("rst_data", bus_a.bus_data, 128'(0));
    tick(); tick();
    rst = 1'b0;

    // Preload and basic request at 0x14
    for (int i = 0; i < 16; i++) wr(32'(i * 4), 32'h1000_0000 + 32'(i));
    bus_a.bus_ldp = 1'b1; bus_a.bus_addr = 32'h14;
    sb.push_back(128'h10000007_10000006_10000005_10000004);
    tick();
    bus_a.bus_ldp = 1'b0;
    mon(0, 10, n, at, nb, d);
    chk("basic_pulses", 128'(n), 128'(1));
    chk("basic_latency", 128'(at), 128'(5));
    chk("basic_busy_cycles", 128'(nb), 128'(5));
    chk("basic_data", d, sb.pop_front());

    // Back-to-back with ldp held high
    bus_a.bus_ldp = 1'b1; bus_a.bus_addr = 32'h0;
    sb.push_back(line_of(32'h0));
    sb.push_back(line_of(32'h10));
    tick();
    bus_a.bus_addr = 32'h10;
    n = 0; at1 = -1; at2 = -1; d1 = '0; d2 = '0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (bus_a.bus_ldr) begin
        n++;
        if (n == 1) begin at1 = c; d1 = bus_a.bus_data; end
        if (n == 2) begin at2 = c; d2 = bus_a.bus_data; bus_a.bus_ldp = 1'b0; end
      end
    end
    bus_a.bus_ldp = 1'b0;
    chk("b2b_pulses", 128'(n), 128'(2));
    chk("b2b_first_at", 128'(at1), 128'(5));
    chk("b2b_spacing", 128'(at2 - at1), 128'(6));
    chk("b2b_line0", d1, sb.pop_front());
    chk("b2b_line1", d2, sb.pop_front());

    // Address wrap
    bus_a.bus_ldp = 1'b1; bus_a.bus_addr = 32'h4000;
    sb.push_back(line_of(32'h0));
    tick();
    bus_a.bus_ldp = 1'b0;
    mon(0, 10, n, at, nb, d);
    chk("wrap_pulses", 128'(n), 128'(1));
    chk("wrap_data", d, sb.pop_front());
    wr(32'h4004, 32'hDEAD_BEEF);
    bus_a.bus_ldp = 1'b1; bus_a.bus_addr = 32'h4000;
    sb.push_back(line_of(32'h4000));
    tick();
    bus_a.bus_ldp = 1'b0;
    mon(0, 10, n, at, nb, d);
    chk("wrap_wr_data", d, sb.pop_front());
    chk("wrap_wr_word1", 128'(d[63:32]), 128'(32'hDEAD_BEEF));

    // Write during WAIT
    bus_a.bus_ldp = 1'b1; bus_a.bus_addr = 32'h20;
    tick();
    bus_a.bus_ldp = 1'b0;
    tick();
    wr(32'h28, 32'hCAFE_F00D);
    sb.push_back(line_of(32'h20));
    mon(0, 8, n, at, nb, d);
    chk("wwait_pulses", 128'(n), 128'(1));
    chk("wwait_at", 128'(at), 128'(3));
    chk("wwait_data", d, sb.pop_front());
    chk("wwait_word2", 128'(d[95:64]), 128'(32'hCAFE_F00D));

    // Write on the same edge that enters RESP
    bus_a.bus_ldp = 1'b1; bus_a.bus_addr = 32'h30;
    tick();
    bus_a.bus_ldp = 1'b0;
    tick(); tick(); tick();
    wr_en = 1'b1; wr_addr = 32'h3C; wr_data = 32'h5A5A_0001;
    model[12'hF] = 32'h5A5A_0001;
    sb.push_back(line_of(32'h30));
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("wfirst_ldr", 128'(bus_a.bus_ldr), 128'(1));
    chk("wfirst_data", bus_a.bus_data, sb.pop_front());
    mon(0, 4, n, at, nb, d);
    chk("wfirst_no_extra", 128'(n), 128'(0));

    // Reset mid-WAIT
    bus_a.bus_ldp = 1'b1; bus_a.bus_addr = 32'h0;
    tick();
    bus_a.bus_ldp = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 128'(busy_a), 128'(0));
    chk("midrst_data", bus_a.bus_data, 128'(0));
    tick();
    rst = 1'b0;
    mon(0, 8, n, at, nb, d);
    chk("midrst_no_ldr", 128'(n), 128'(0));
    chk("midrst_idle", 128'(nb), 128'(0));
    bus_a.bus_ldp = 1'b1; bus_a.bus_addr = 32'h0;
    sb.push_back(line_of(32'h0));
    tick();
    bus_a.bus_ldp = 1'b0;
    mon(0, 10, n, at, nb, d);
    chk("postrst_pulses", 128'(n), 128'(1));
    chk("postrst_at", 128'(at), 128'(5));
    chk("postrst_data", d, sb.pop_front());

    // LATENCY=1 with address changed while busy
    bus_b.bus_ldp = 1'b1; bus_b.bus_addr = 32'h10;
    sb.push_back(line_of(32'h10));
    tick();
    bus_b.bus_ldp = 1'b0; bus_b.bus_addr = 32'h20;
    mon(1, 6, n, at, nb, d);
    chk("lat1_pulses", 128'(n), 128'(1));
    chk("lat1_at", 128'(at), 128'(2));
    chk("lat1_busy_cycles", 128'(nb), 128'(2));
    chk("lat1_data", d, sb.pop_front());

    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
